// File: rtl/bcd_pkg.sv
// Shared BCD constants, nibble type and load sanitizer for the 4-digit counter.
package bcd_pkg;

  localparam int unsigned NDIG    = 4;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned PRE_W   = 26;

  typedef logic [NIB_W-1:0] nibble_t;

  localparam nibble_t BCD_MAX = 4'd9;
  localparam nibble_t BCD_MIN = 4'd0;

  // Codes A-F are never allowed into the count; they load as zero.
  function automatic nibble_t bcd_sanitize(input nibble_t n);
    return (n > BCD_MAX) ? BCD_MIN : n;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: holds a digit 0..9, steps up/down and flags carry/borrow.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    load,
  input  nibble_t load_val,
  input  logic    step_in,
  input  logic    up,
  output nibble_t q,
  output logic    step_out
);

  nibble_t r_q;

  // Digit register: reset > load > step > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= BCD_MIN;
    end else if (load) begin
      r_q <= bcd_sanitize(load_val);
    end else if (step_in) begin
      if (up) begin
        r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + NIB_W'(1);
      end else begin
        r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - NIB_W'(1);
      end
    end
  end

  assign q        = r_q;
  // Ripple to the next decade when this one rolls over in the chosen direction.
  assign step_out = step_in && ((up && (r_q == BCD_MAX)) || (!up && (r_q == BCD_MIN)));

endmodule

// File: rtl/bcd_counter_4dig.sv
// Four-digit BCD up/down counter with prescaler, parallel load and wrap pulse.
module bcd_counter_4dig
  import bcd_pkg::*;
#(
  parameter int unsigned DIV = 50000000
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic                    EN,
  input  logic                    UP,
  input  logic                    LOAD,
  input  logic [NDIG*NIB_W-1:0]   LOAD_VAL,
  output logic [NDIG*NIB_W-1:0]   BCD_OUT,
  output logic                    TICK,
  output logic                    WRAP
);

  logic [PRE_W-1:0] r_pre;
  logic             r_wrap;
  logic             w_pre_term;
  logic             w_step;
  logic [NDIG:0]    w_chain;

  assign w_pre_term = (r_pre == PRE_W'(DIV - 1));
  assign w_step     = EN && w_pre_term && !LOAD && !RESET;

  // Prescaler: counts enabled cycles, cleared by reset or load.
  always_ff @(posedge CLOCK_50) begin
    if (RESET || LOAD) begin
      r_pre <= '0;
    end else if (EN) begin
      r_pre <= w_pre_term ? '0 : r_pre + PRE_W'(1);
    end
  end

  assign w_chain[0] = w_step;

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (CLOCK_50),
      .reset    (RESET),
      .load     (LOAD),
      .load_val (LOAD_VAL[g*NIB_W +: NIB_W]),
      .step_in  (w_chain[g]),
      .up       (UP),
      .q        (BCD_OUT[g*NIB_W +: NIB_W]),
      .step_out (w_chain[g+1])
    );
  end

  // Wrap flag: registered alongside the update that rolls past the last digit.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_chain[NDIG];
    end
  end

  assign TICK = w_step;
  assign WRAP = r_wrap;

endmodule

// File: tb/tb_bcd_counter_4dig.sv
// Directed bench for bcd_counter_4dig with DIV=4.
`timescale 1ns/1ps
module tb_bcd_counter_4dig;

  logic        clk;
  logic        RESET;
  logic        EN;
  logic        UP;
  logic        LOAD;
  logic [15:0] LOAD_VAL;
  logic [15:0] BCD_OUT;
  logic        TICK;
  logic        WRAP;

  int n_checks;
  int n_fail;

  bcd_counter_4dig #(.DIV(4)) dut (
    .CLOCK_50 (clk),
    .RESET    (RESET),
    .EN       (EN),
    .UP       (UP),
    .LOAD     (LOAD),
    .LOAD_VAL (LOAD_VAL),
    .BCD_OUT  (BCD_OUT),
    .TICK     (TICK),
    .WRAP     (WRAP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_bcd;
    logic        exp_tick;
    RESET = 1'b1; EN = 1'b1; UP = 1'b1; LOAD = 1'b0; LOAD_VAL = 16'h0000;
    cyc(); cyc();
    n_checks++; if (BCD_OUT !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd: got %h want 0000", BCD_OUT); end
    n_checks++; if (TICK !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", TICK); end
    n_checks++; if (WRAP !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", WRAP); end
    RESET = 1'b0; #1;
    n_checks++; if (TICK !== 1'b0) begin n_fail++; $display("FAIL reset_rel_tick: got %b want 0", TICK); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      exp_tick = (i == 2);
      exp_bcd  = (i < 3) ? 16'h0000 : 16'h0001;
      n_checks++; if (TICK !== exp_tick) begin n_fail++; $display("FAIL reset_first_tick[%0d]: got %b want %b", i, TICK, exp_tick); end
      n_checks++; if (BCD_OUT !== exp_bcd) begin n_fail++; $display("FAIL reset_first_step[%0d]: got %h want %h", i, BCD_OUT, exp_bcd); end
    end
  endtask

  task automatic test_up_carry();
    logic [15:0] exp_bcd;
    logic        exp_tick;
    UP = 1'b1; EN = 1'b1; LOAD = 1'b1; LOAD_VAL = 16'h0998;
    cyc();
    LOAD = 1'b0; #1;
    n_checks++; if (BCD_OUT !== 16'h0998) begin n_fail++; $display("FAIL carry_load: got %h want 0998", BCD_OUT); end
    for (int i = 0; i < 8; i++) begin
      cyc();
      exp_tick = ((i % 4) == 2);
      exp_bcd  = (i < 3) ? 16'h0998 : ((i < 7) ? 16'h0999 : 16'h1000);
      n_checks++; if (TICK !== exp_tick) begin n_fail++; $display("FAIL carry_tick[%0d]: got %b want %b", i, TICK, exp_tick); end
      n_checks++; if (BCD_OUT !== exp_bcd) begin n_fail++; $display("FAIL carry_bcd[%0d]: got %h want %h", i, BCD_OUT, exp_bcd); end
      n_checks++; if (WRAP !== 1'b0) begin n_fail++; $display("FAIL carry_wrap[%0d]: got %b want 0", i, WRAP); end
    end
  endtask

  task automatic test_up_wrap();
    logic [15:0] exp_bcd;
    logic        exp_wrap;
    UP = 1'b1; EN = 1'b1; LOAD = 1'b1; LOAD_VAL = 16'h9999;
    cyc();
    LOAD = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      exp_bcd  = (i < 3) ? 16'h9999 : 16'h0000;
      exp_wrap = (i == 3);
      n_checks++; if (BCD_OUT !== exp_bcd) begin n_fail++; $display("FAIL upwrap_bcd[%0d]: got %h want %h", i, BCD_OUT, exp_bcd); end
      n_checks++; if (WRAP !== exp_wrap) begin n_fail++; $display("FAIL upwrap_wrap[%0d]: got %b want %b", i, WRAP, exp_wrap); end
    end
  endtask

  task automatic test_down();
    logic [15:0] exp_bcd;
    logic        exp_wrap;
    UP = 1'b0; EN = 1'b1; LOAD = 1'b1; LOAD_VAL = 16'h1000;
    cyc();
    LOAD = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      exp_bcd = (i < 3) ? 16'h1000 : 16'h0999;
      n_checks++; if (BCD_OUT !== exp_bcd) begin n_fail++; $display("FAIL borrow_bcd[%0d]: got %h want %h", i, BCD_OUT, exp_bcd); end
      n_checks++; if (WRAP !== 1'b0) begin n_fail++; $display("FAIL borrow_wrap[%0d]: got %b want 0", i, WRAP); end
    end
    LOAD = 1'b1; LOAD_VAL = 16'h0000;
    cyc();
    LOAD = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      exp_bcd  = (i < 3) ? 16'h0000 : 16'h9999;
      exp_wrap = (i == 3);
      n_checks++; if (BCD_OUT !== exp_bcd) begin n_fail++; $display("FAIL dnwrap_bcd[%0d]: got %h want %h", i, BCD_OUT, exp_bcd); end
      n_checks++; if (WRAP !== exp_wrap) begin n_fail++; $display("FAIL dnwrap_wrap[%0d]: got %b want %b", i, WRAP, exp_wrap); end
    end
  endtask

  task automatic test_load_sanitize();
    EN = 1'b0; LOAD = 1'b1; LOAD_VAL = 16'hA5F3;
    cyc();
    LOAD = 1'b0; #1;
    n_checks++; if (BCD_OUT !== 16'h0503) begin n_fail++; $display("FAIL sanitize: got %h want 0503", BCD_OUT); end
    LOAD = 1'b1; LOAD_VAL = 16'hB7CE;
    cyc();
    LOAD = 1'b0; #1;
    n_checks++; if (BCD_OUT !== 16'h0700) begin n_fail++; $display("FAIL sanitize2: got %h want 0700", BCD_OUT); end
  endtask

  task automatic test_load_priority();
    logic [15:0] exp_bcd;
    logic        exp_tick;
    UP = 1'b1; EN = 1'b1; LOAD = 1'b1; LOAD_VAL = 16'h9999;
    cyc();
    LOAD = 1'b0; #1;
    cyc(); cyc(); cyc();
    n_checks++; if (TICK !== 1'b1) begin n_fail++; $display("FAIL prio_pre_tick: got %b want 1", TICK); end
    LOAD = 1'b1; LOAD_VAL = 16'h4321; #1;
    n_checks++; if (TICK !== 1'b0) begin n_fail++; $display("FAIL prio_tick_masked: got %b want 0", TICK); end
    cyc();
    LOAD = 1'b0; #1;
    n_checks++; if (BCD_OUT !== 16'h4321) begin n_fail++; $display("FAIL prio_bcd: got %h want 4321", BCD_OUT); end
    n_checks++; if (WRAP !== 1'b0) begin n_fail++; $display("FAIL prio_wrap: got %b want 0", WRAP); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      exp_tick = (i == 2);
      exp_bcd  = (i < 3) ? 16'h4321 : 16'h4322;
      n_checks++; if (TICK !== exp_tick) begin n_fail++; $display("FAIL prio_restart_tick[%0d]: got %b want %b", i, TICK, exp_tick); end
      n_checks++; if (BCD_OUT !== exp_bcd) begin n_fail++; $display("FAIL prio_restart_bcd[%0d]: got %h want %h", i, BCD_OUT, exp_bcd); end
    end
  endtask

  task automatic test_reset_load();
    logic        exp_tick;
    EN = 1'b1; UP = 1'b1; cyc();
    RESET = 1'b1; LOAD = 1'b1; LOAD_VAL = 16'h5555;
    cyc();
    RESET = 1'b0; LOAD = 1'b0; #1;
    n_checks++; if (BCD_OUT !== 16'h0000) begin n_fail++; $display("FAIL rst_load_bcd: got %h want 0000", BCD_OUT); end
    n_checks++; if (WRAP !== 1'b0) begin n_fail++; $display("FAIL rst_load_wrap: got %b want 0", WRAP); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      exp_tick = (i == 2);
      n_checks++; if (TICK !== exp_tick) begin n_fail++; $display("FAIL rst_load_tick[%0d]: got %b want %b", i, TICK, exp_tick); end
    end
    cyc();
  endtask

  task automatic test_enable_hold();
    RESET = 1'b1; EN = 1'b1; UP = 1'b1; LOAD = 1'b0;
    cyc();
    RESET = 1'b0;
    cyc(); cyc();
    EN = 1'b0; #1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_checks++; if (BCD_OUT !== 16'h0000) begin n_fail++; $display("FAIL hold_bcd[%0d]: got %h want 0000", i, BCD_OUT); end
      n_checks++; if (TICK !== 1'b0) begin n_fail++; $display("FAIL hold_tick[%0d]: got %b want 0", i, TICK); end
    end
    EN = 1'b1; #1;
    n_checks++; if (TICK !== 1'b0) begin n_fail++; $display("FAIL resume_tick0: got %b want 0", TICK); end
    cyc();
    n_checks++; if (TICK !== 1'b1) begin n_fail++; $display("FAIL resume_tick1: got %b want 1", TICK); end
    cyc();
    n_checks++; if (BCD_OUT !== 16'h0001) begin n_fail++; $display("FAIL resume_bcd: got %h want 0001", BCD_OUT); end
    n_checks++; if (TICK !== 1'b0) begin n_fail++; $display("FAIL resume_tick2: got %b want 0", TICK); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RESET = 1'b1; EN = 1'b0; UP = 1'b1; LOAD = 1'b0; LOAD_VAL = 16'h0000;
    test_reset();
    test_up_carry();
    test_up_wrap();
    test_down();
    test_load_sanitize();
    test_load_priority();
    test_reset_load();
    test_enable_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
